// File: rtl/srch_pkg.sv
// -----------------------------------------------------------------------------
// srch_pkg
// Shared definitions for the search/compare stage: table geometry, the FSM
// state encoding and the three-way compare result code.
// -----------------------------------------------------------------------------
package srch_pkg;

    localparam int SRCH_DEPTH = 8;
    localparam int SRCH_IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        DONE = 2'b10
    } srchState_t;

    // Result of comparing a table entry against the search key
    typedef enum logic [1:0] {
        CMP_LT = 2'b00,
        CMP_EQ = 2'b01,
        CMP_GT = 2'b10
    } cmpRes_t;

endpackage

// File: rtl/srch_cmp.sv
// -----------------------------------------------------------------------------
// srch_cmp
// Combinational unsigned comparator: reports whether the table entry is
// less than, equal to or greater than the search key.
// Ports:
//   i_entry  - table entry under test
//   i_key    - captured search key
//   o_res    - CMP_LT / CMP_EQ / CMP_GT (entry relative to key)
// -----------------------------------------------------------------------------
module srch_cmp
    import srch_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] i_entry,
    input  logic [DATA_W-1:0] i_key,
    output cmpRes_t           o_res
);

    // Full-width unsigned three-way compare
    always_comb begin
        o_res = CMP_GT;
        if (i_entry < i_key) begin
            o_res = CMP_LT;
        end else if (i_entry == i_key) begin
            o_res = CMP_EQ;
        end
    end

endmodule

// File: rtl/srch_cmp_unit.sv
// -----------------------------------------------------------------------------
// srch_cmp_unit
// Search/compare stage. Holds an 8-entry sorted key table with valid bits and,
// on request, scans it one entry per cycle against a captured key.
// Ports:
//   clk, reset         - clock, asynchronous active-high reset
//   enb_srch, key      - start a search with this key (IDLE only)
//   wr_en, wr_addr,
//   wr_data            - write one table entry and set its valid bit (IDLE only)
//   clr                - clear all valid bits (IDLE only, wins over wr_en)
//   out_incoder        - stop index of the last search
//   sam_srch_1         - exact match at out_incoder
//   sam_srch_2         - key beyond every valid entry scanned
//   seach_end          - one-cycle pulse when results update
//   busy               - high while scanning or reporting
// -----------------------------------------------------------------------------
module srch_cmp_unit
    import srch_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = SRCH_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enb_srch,
    input  logic [DATA_W-1:0]     key,
    input  logic                  wr_en,
    input  logic [SRCH_IDX_W-1:0] wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  clr,
    output logic [SRCH_IDX_W-1:0] out_incoder,
    output logic                  sam_srch_1,
    output logic                  sam_srch_2,
    output logic                  seach_end,
    output logic                  busy
);

    srchState_t            r_state;
    srchState_t            w_nextState;
    logic [DATA_W-1:0]     r_table [DEPTH];
    logic [DEPTH-1:0]      r_vld;
    logic [DATA_W-1:0]     r_keyQ;
    logic [SRCH_IDX_W-1:0] r_idx;

    cmpRes_t               w_cmp;
    logic                  w_stop;
    logic                  w_sam1;
    logic                  w_sam2;

    // Single comparator shared across the scan, fed by the entry at r_idx
    srch_cmp #(
        .DATA_W (DATA_W)
    ) u_cmp (
        .i_entry (r_table[r_idx]),
        .i_key   (r_keyQ),
        .o_res   (w_cmp)
    );

    // Next-state logic and stop decision. An invalid entry means the key sits
    // past the populated part of the table, so it reports "beyond" just like
    // running off the last slot with a smaller entry.
    always_comb begin
        w_nextState = r_state;
        w_stop      = 1'b0;
        w_sam1      = 1'b0;
        w_sam2      = 1'b0;
        seach_end   = 1'b0;
        busy        = 1'b1;
        unique case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (enb_srch) begin
                    w_nextState = SCAN;
                end
            end
            SCAN: begin
                if (!r_vld[r_idx]) begin
                    w_stop = 1'b1;
                    w_sam2 = 1'b1;
                end else if (w_cmp == CMP_EQ) begin
                    w_stop = 1'b1;
                    w_sam1 = 1'b1;
                end else if (w_cmp == CMP_GT) begin
                    w_stop = 1'b1;
                end else if (r_idx == SRCH_IDX_W'(SRCH_DEPTH - 1)) begin
                    w_stop = 1'b1;
                    w_sam2 = 1'b1;
                end
                if (w_stop) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                seach_end   = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Table maintenance and search datapath. Writes and clears are only taken
    // in IDLE; a write in the same cycle as a search start lands before the
    // first compare because that compare happens in the following cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_table     <= '{default: '0};
            r_vld       <= '0;
            r_keyQ      <= '0;
            r_idx       <= '0;
            out_incoder <= '0;
            sam_srch_1  <= 1'b0;
            sam_srch_2  <= 1'b0;
        end else begin
            if (r_state == IDLE) begin
                if (wr_en) begin
                    r_table[wr_addr] <= wr_data;
                end
                if (clr) begin
                    r_vld <= '0;
                end else if (wr_en) begin
                    r_vld[wr_addr] <= 1'b1;
                end
                if (enb_srch) begin
                    r_keyQ <= key;
                    r_idx  <= '0;
                end
            end else if (r_state == SCAN) begin
                if (w_stop) begin
                    out_incoder <= r_idx;
                    sam_srch_1  <= w_sam1;
                    sam_srch_2  <= w_sam2;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_srch_cmp_unit.sv
// -----------------------------------------------------------------------------
// tb_srch_cmp_unit
// Self-checking bench for srch_cmp_unit: directed scenarios followed by
// randomized table updates and searches, checked against a reference model
// of the search rules.
// -----------------------------------------------------------------------------
module tb_srch_cmp_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       enb_srch;
    logic [7:0] key;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       clr;
    logic [2:0] out_incoder;
    logic       sam_srch_1;
    logic       sam_srch_2;
    logic       seach_end;
    logic       busy;

    int testCount = 0;
    int failCount = 0;
    int cyc = 0;

    logic [7:0] mdlTable [8];
    bit         mdlVld [8];
    int         pendStart = -1;
    int         pendEnd = -1;
    int         pendOut = 0;
    bit         pendS1 = 1'b0;
    bit         pendS2 = 1'b0;
    int         curOut = 0;
    bit         curS1 = 1'b0;
    bit         curS2 = 1'b0;

    srch_cmp_unit #(
        .DATA_W (8),
        .DEPTH  (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enb_srch    (enb_srch),
        .key         (key),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .clr         (clr),
        .out_incoder (out_incoder),
        .sam_srch_1  (sam_srch_1),
        .sam_srch_2  (sam_srch_2),
        .seach_end   (seach_end),
        .busy        (busy)
    );

    // Free-running clock and an edge counter used to schedule expectations
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // One comparison: counts it, reports it on mismatch
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Reference search: the scan stops at the first slot that is empty or
    // whose entry is not below the key; with no such slot it stops at 7.
    task automatic modelSearch(input logic [7:0] k, output int sOut, output bit s1, output bit s2);
        sOut = 7;
        for (int i = 0; i < 8; i++) begin
            if (!mdlVld[i] || mdlTable[i] >= k) begin
                sOut = i;
                break;
            end
        end
        s1 = mdlVld[sOut] && (mdlTable[sOut] == k);
        s2 = !mdlVld[sOut] || (mdlTable[sOut] < k);
    endtask

    task automatic modelReset();
        for (int i = 0; i < 8; i++) begin
            mdlTable[i] = 8'd0;
            mdlVld[i]   = 1'b0;
        end
        curOut    = 0;
        curS1     = 1'b0;
        curS2     = 1'b0;
        pendStart = -1;
        pendEnd   = -1;
    endtask

    // Per-cycle compare against the scheduled model state
    always @(negedge clk) begin
        bit expBusy;
        bit expEnd;
        if (pendEnd >= 0 && cyc == pendEnd) begin
            curOut = pendOut;
            curS1  = pendS1;
            curS2  = pendS2;
        end
        expBusy = (pendEnd >= 0) && (cyc >= pendStart) && (cyc <= pendEnd);
        expEnd  = (pendEnd >= 0) && (cyc == pendEnd);
        checkOutput("busy", 32'(busy), 32'(expBusy));
        checkOutput("seach_end", 32'(seach_end), 32'(expEnd));
        checkOutput("out_incoder", 32'(out_incoder), 32'(curOut));
        checkOutput("sam_srch_1", 32'(sam_srch_1), 32'(curS1));
        checkOutput("sam_srch_2", 32'(sam_srch_2), 32'(curS2));
    end

    task automatic writeEntry(input logic [2:0] a, input logic [7:0] d);
        @(posedge clk); #2;
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        mdlTable[a] = d;
        mdlVld[a]   = 1'b1;
        @(posedge clk); #2;
        wr_en = 1'b0;
    endtask

    // Clear, optionally with a write in the same cycle (data kept, not valid)
    task automatic clearTable(input bit withWrite, input logic [2:0] a, input logic [7:0] d);
        @(posedge clk); #2;
        clr = 1'b1;
        if (withWrite) begin
            wr_en = 1'b1; wr_addr = a; wr_data = d;
            mdlTable[a] = d;
        end
        for (int i = 0; i < 8; i++) mdlVld[i] = 1'b0;
        @(posedge clk); #2;
        clr = 1'b0; wr_en = 1'b0;
    endtask

    // Runs one search, optionally with a same-cycle write and with start/write/
    // clear pokes while busy (which must have no effect).
    task automatic applyStimulus(input logic [7:0] k, input bit alsoWrite, input logic [2:0] wa,
                                 input logic [7:0] wd, input bit pokeBusy,
                                 output int gotOut, output bit gotS1, output bit gotS2, output int lat);
        int mOut;
        bit mS1;
        bit mS2;
        int n;
        @(posedge clk); #2;
        enb_srch = 1'b1; key = k;
        if (alsoWrite) begin
            wr_en = 1'b1; wr_addr = wa; wr_data = wd;
            mdlTable[wa] = wd;
            mdlVld[wa]   = 1'b1;
        end
        modelSearch(k, mOut, mS1, mS2);
        @(posedge clk); #1;
        pendStart = cyc;
        pendEnd   = cyc + mOut + 1;
        pendOut   = mOut;
        pendS1    = mS1;
        pendS2    = mS2;
        #1;
        enb_srch = 1'b0; wr_en = 1'b0;
        lat = -1;
        n   = 0;
        while (n < 12) begin
            @(negedge clk);
            if (pokeBusy && n == 1) begin
                enb_srch = 1'b1; key = 8'd0;
                wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'd45;
            end
            if (pokeBusy && n == 2) begin
                enb_srch = 1'b0; wr_en = 1'b0; clr = 1'b1;
            end
            if (pokeBusy && n == 3) clr = 1'b0;
            if (seach_end === 1'b1) begin
                lat = n;
                break;
            end
            n++;
        end
        enb_srch = 1'b0; wr_en = 1'b0; clr = 1'b0;
        if (lat < 0) checkOutput("search_completed", 32'd0, 32'd1);
        checkOutput("latency_model", 32'(lat), 32'(mOut + 1));
        gotOut = int'(out_incoder);
        gotS1  = sam_srch_1;
        gotS2  = sam_srch_2;
    endtask

    // Directed search with hand-computed expectations
    task automatic directed(input string name, input logic [7:0] k, input bit alsoWrite,
                            input logic [2:0] wa, input logic [7:0] wd, input bit pokeBusy,
                            input int eOut, input bit eS1, input bit eS2, input int eLat);
        int gOut;
        bit gS1;
        bit gS2;
        int gLat;
        applyStimulus(k, alsoWrite, wa, wd, pokeBusy, gOut, gS1, gS2, gLat);
        checkOutput({name, "_out"}, 32'(gOut), 32'(eOut));
        checkOutput({name, "_sam1"}, 32'(gS1), 32'(eS1));
        checkOutput({name, "_sam2"}, 32'(gS2), 32'(eS2));
        checkOutput({name, "_lat"}, 32'(gLat), 32'(eLat));
    endtask

    initial begin
        int gOut;
        bit gS1;
        bit gS2;
        int gLat;
        logic [7:0] base;

        reset = 1'b1;
        enb_srch = 1'b1; key = 8'hA5; wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'h5A; clr = 1'b0;
        modelReset();
        repeat (3) @(posedge clk);
        #2;
        enb_srch = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; key = '0;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_out", 32'(out_incoder), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);

        // Empty table right after reset: every slot invalid
        directed("empty", 8'd77, 1'b0, 3'd0, 8'd0, 1'b0, 0, 1'b0, 1'b1, 1);

        writeEntry(3'd0, 8'd10);
        writeEntry(3'd1, 8'd20);
        writeEntry(3'd2, 8'd30);
        writeEntry(3'd3, 8'd40);
        directed("key30", 8'd30, 1'b0, 3'd0, 8'd0, 1'b0, 2, 1'b1, 1'b0, 3);
        directed("key25", 8'd25, 1'b0, 3'd0, 8'd0, 1'b0, 2, 1'b0, 1'b0, 3);
        directed("key5",  8'd5,  1'b0, 3'd0, 8'd0, 1'b0, 0, 1'b0, 1'b0, 1);
        directed("key50", 8'd50, 1'b0, 3'd0, 8'd0, 1'b1, 4, 1'b0, 1'b1, 5);
        directed("key50b", 8'd50, 1'b0, 3'd0, 8'd0, 1'b0, 4, 1'b0, 1'b1, 5);
        directed("key30b", 8'd30, 1'b0, 3'd0, 8'd0, 1'b0, 2, 1'b1, 1'b0, 3);

        for (int i = 0; i < 8; i++) writeEntry(3'(i), 8'(i + 1));
        directed("key200", 8'd200, 1'b0, 3'd0, 8'd0, 1'b0, 7, 1'b0, 1'b1, 8);
        directed("key1",   8'd1,   1'b0, 3'd0, 8'd0, 1'b0, 0, 1'b1, 1'b0, 1);
        directed("key8",   8'd8,   1'b0, 3'd0, 8'd0, 1'b0, 7, 1'b1, 1'b0, 8);

        // Reset during the third scan cycle of a long search
        @(posedge clk); #2;
        enb_srch = 1'b1; key = 8'd200;
        modelSearch(8'd200, pendOut, pendS1, pendS2);
        @(posedge clk); #1;
        pendStart = cyc;
        pendEnd   = cyc + pendOut + 1;
        #1;
        enb_srch = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        modelReset();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("midrst_out", 32'(out_incoder), 32'd0);

        directed("after_rst", 8'd9, 1'b0, 3'd0, 8'd0, 1'b0, 0, 1'b0, 1'b1, 1);
        clearTable(1'b1, 3'd0, 8'd9);
        directed("clr_wr", 8'd9, 1'b0, 3'd0, 8'd0, 1'b0, 0, 1'b0, 1'b1, 1);
        directed("wr_srch", 8'd9, 1'b1, 3'd0, 8'd9, 1'b0, 0, 1'b1, 1'b0, 1);

        // Randomized table maintenance and searches against the model
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 4) == 0) clearTable(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                base = 8'($urandom_range(0, 20));
                for (int i = 0; i < 8; i++) begin
                    base = base + 8'($urandom_range(1, 30));
                    writeEntry(3'(i), base);
                end
            end else begin
                repeat ($urandom_range(0, 2)) writeEntry(3'($urandom_range(0, 7)), 8'($urandom));
            end
            if ($urandom_range(0, 1) == 0)
                applyStimulus(mdlTable[$urandom_range(0, 7)], 1'b0, 3'd0, 8'd0, 1'b0, gOut, gS1, gS2, gLat);
            else
                applyStimulus(8'($urandom), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
                              1'b0, gOut, gS1, gS2, gLat);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
